adder_seq_ctrl: RTL and testbench

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

---
 rtl/adder_seq_pkg.sv | 20 ++
 rtl/adder16.sv | 19 +
 rtl/adder_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_adder_seq_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared constants and types for the sequential slice adder.
//   SLICE_W   : width of one adder slice (the shared 16-bit adder)
//   state_e   : controller FSM states
//   idx_width : width needed for a slice index over nslice slices
package adder_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single-slice build still needs a 1-bit index register.
  function automatic int idx_width(input int nslice);
    return (nslice <= 1) ? 1 : $clog2(nslice);
  endfunction

endpackage

// File: rtl/adder16.sv
// adder16: purely combinational 16-bit adder, one slice of the sequential adder.
// Ports:
//   c_in  : carry into bit 0
//   A, B  : 16-bit operands
//   sum   : 16-bit result
//   c_out : carry out of bit 15
module adder16
  import adder_seq_pkg::*;
(
  input  logic               c_in,
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  output logic [SLICE_W-1:0] sum,
  output logic               c_out
);

  assign {c_out, sum} = {1'b0, A} + {1'b0, B} + {{SLICE_W{1'b0}}, c_in};

endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: W-bit adder built from one shared 16-bit adder, stepped over
// NSLICE cycles least-significant slice first, with a valid/ready handshake on
// both request and response sides.
//
// Optional feature macro: ADDER_SEQ_ADD_SUB_EN adds the sub port (subtract).
//
// Ports:
//   clk       : sole clock, rising edge
//   rst       : synchronous active-high reset
//   req_valid : request present          req_ready : block can accept (IDLE)
//   A, B      : W-bit operands           c_in      : carry into slice 0
//   sub       : subtract select (only with ADDER_SEQ_ADD_SUB_EN)
//   rsp_valid : result valid (DONE)      rsp_ready : consumer takes result
//   sum       : W-bit result
//   c_out     : carry out of bit W-1     overflow  : signed overflow
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request, req_ready=1
// CALC  | adding slice idx per edge, carry held in carry_q
// DONE  | result held, rsp_valid=1, waits for rsp_ready
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter  int NSLICE = 4,
  localparam int W      = SLICE_W * NSLICE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         c_in,
`ifdef ADDER_SEQ_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         overflow
);

  localparam int IW = idx_width(NSLICE);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_CALC = ST_CALC;
  localparam logic [1:0] S_DONE = ST_DONE;

  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  logic [1:0]         state;
  logic [IW-1:0]      idx;
  logic               carry_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic               c_out_q;
  logic               ovf_q;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_carry;
  logic               accept_cin;

`ifdef ADDER_SEQ_ADD_SUB_EN
  logic sub_q;

  // Subtraction is A + ~B + 1: the forced carry replaces c_in.
  assign accept_cin = sub ? 1'b1 : c_in;
  assign slice_b    = sub_q ? ~b_q[idx*SLICE_W +: SLICE_W]
                            :  b_q[idx*SLICE_W +: SLICE_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else if (state == S_IDLE && req_valid) begin
      sub_q <= sub;
    end
  end
`else
  assign accept_cin = c_in;
  assign slice_b    = b_q[idx*SLICE_W +: SLICE_W];
`endif

  assign slice_a = a_q[idx*SLICE_W +: SLICE_W];

  adder16 u_adder16 (
    .c_in  (carry_q),
    .A     (slice_a),
    .B     (slice_b),
    .sum   (slice_sum),
    .c_out (slice_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= accept_cin;
            idx     <= '0;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          sum_q[idx*SLICE_W +: SLICE_W] <= slice_sum;
          carry_q <= slice_carry;
          if (idx == LAST_IDX) begin
            idx     <= '0;
            c_out_q <= slice_carry;
            // Top-slice operand MSBs agree but the result sign differs.
            ovf_q   <= (slice_a[SLICE_W-1] == slice_b[SLICE_W-1]) &&
                       (slice_sum[SLICE_W-1] != slice_a[SLICE_W-1]);
            state   <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          // The leaving edge returns to IDLE only; acceptance waits an edge.
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
module tb_adder_seq_ctrl;

  localparam int NSLICE = 4;
  localparam int W      = 16 * NSLICE;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         c_in;
  logic         sub;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  always #5 clk = ~clk;

  adder_seq_ctrl #(.NSLICE(NSLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .A         (A),
    .B         (B),
    .c_in      (c_in),
`ifdef ADDER_SEQ_ADD_SUB_EN
    .sub       (sub),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sb_sel);
    logic [W:0]   t;
    logic [W-1:0] bb;
    logic         cc;
    exp_t         e;
    bb = sb_sel ? ~b : b;
    cc = sb_sel ? 1'b1 : ci;
    t  = {1'b0, a} + {1'b0, bb} + (W+1)'(cc);
    e.sum   = t[W-1:0];
    e.c_out = t[W];
    e.ovf   = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return e;
  endfunction

  logic sub_en;

  task automatic scramble();
    A    = {$urandom, $urandom};
    B    = {$urandom, $urandom};
    c_in = $urandom_range(0, 1);
    sub  = $urandom_range(0, 1);
  endtask

  // Drive one request from IDLE; push the expectation on the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sb_sel);
    @(negedge clk);
    chk("req_ready_idle", W'(req_ready), W'(1));
    req_valid = 1'b1;
    A = a; B = b; c_in = ci; sub = sb_sel;
    @(posedge clk);
    sb.push_back(model(a, b, ci, sub_en & sb_sel));
    @(negedge clk);
    req_valid = 1'b0;
    scramble();
    chk("req_ready_busy", W'(req_ready), W'(0));
  endtask

  // Called at the negedge after the accepting edge; counts edges to rsp_valid.
  task automatic await_rsp(input string tag, output exp_t e);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, W'(n), W'(NSLICE));
    chk({tag, "_sb_depth"}, W'(sb.size()), W'(1));
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk({tag, "_sum"}, sum, e.sum);
    chk({tag, "_c_out"}, W'(c_out), W'(e.c_out));
    chk({tag, "_overflow"}, W'(overflow), W'(e.ovf));
    chk({tag, "_req_ready_done"}, W'(req_ready), W'(0));
  endtask

  task automatic release_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_after"}, W'(rsp_valid), W'(0));
    chk({tag, "_req_ready_after"}, W'(req_ready), W'(1));
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sb_sel);
    exp_t e;
    issue(a, b, ci, sb_sel);
    await_rsp(tag, e);
    release_rsp(tag);
  endtask

  task automatic mid_calc_reset(input string tag, input logic sb_sel);
    issue(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, sb_sel);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_no_rsp"}, W'(rsp_valid), W'(0));
      @(posedge clk);
      @(negedge clk);
    end
    chk({tag, "_req_ready"}, W'(req_ready), W'(1));
    chk({tag, "_sum_clear"}, sum, W'(0));
  endtask

  initial begin
    exp_t e;
`ifdef ADDER_SEQ_ADD_SUB_EN
    sub_en = 1'b1;
`else
    sub_en = 1'b0;
`endif
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    A = '0; B = '0; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", W'(req_ready), W'(1));
    chk("rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("rst_sum", sum, W'(0));
    chk("rst_c_out", W'(c_out), W'(0));
    chk("rst_overflow", W'(overflow), W'(0));

    run_one("carry_chain", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    run_one("full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    run_one("overflow",    64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    run_one("neg_ovf",     64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);

    // Backpressure: result held for 10 cycles while rsp_ready stays low.
    issue(64'hDEAD_BEEF_0123_4567, 64'h1111_2222_F00D_CAFE, 1'b1, 1'b0);
    await_rsp("bp", e);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_rsp_valid", W'(rsp_valid), W'(1));
      chk("bp_req_ready", W'(req_ready), W'(0));
      chk("bp_sum", sum, e.sum);
      chk("bp_c_out", W'(c_out), W'(e.c_out));
    end
    release_rsp("bp");

    // No acceptance on the edge that leaves DONE; accepted one edge later.
    issue(64'h0000_0001_0000_0001, 64'h0000_FFFF_0000_FFFF, 1'b0, 1'b0);
    await_rsp("turn_a", e);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    A = 64'h0123_4567_89AB_CDEF; B = 64'hFEDC_BA98_7654_3210; c_in = 1'b1; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("turn_not_accepted", W'(req_ready), W'(1));
    chk("turn_rsp_valid", W'(rsp_valid), W'(0));
    @(posedge clk);
    sb.push_back(model(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0));
    @(negedge clk);
    req_valid = 1'b0;
    scramble();
    chk("turn_accepted", W'(req_ready), W'(0));
    await_rsp("turn_b", e);
    release_rsp("turn_b");

    mid_calc_reset("rst_calc", 1'b0);

    for (int k = 0; k < 4; k++) begin
      run_one("rand", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef ADDER_SEQ_ADD_SUB_EN
    run_one("sub_5_7", 64'd5, 64'd7, 1'b0, 1'b1);
    run_one("sub_cin_ignored", 64'd5, 64'd7, 1'b1, 1'b1);
    run_one("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    mid_calc_reset("sub_rst_calc", 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
